// File: rtl/sys_clk_ce_gen_if.sv
// Output bundle of the fractional clock-enable generator, plus the power-down request.
// The generator uses the master modport. The consumer (the system-domain logic) uses the slave modport.
interface sys_clk_ce_gen_if;
   logic pwrdwn;
   logic ce_out;
   logic clk_out;
   logic locked;
   logic param_err;

   modport master (
      input  pwrdwn,
      output ce_out,
      output clk_out,
      output locked,
      output param_err
   );

   modport slave (
      output pwrdwn,
      input  ce_out,
      input  clk_out,
      input  locked,
      input  param_err
   );
endinterface

// File: rtl/sys_clk_ce_gen.sv
// Single-clock stand-in for the system PLL. It emits N enable strobes and N square-wave
// periods every D input cycles, after a fixed lock delay.
module sys_clk_ce_gen #(
   parameter int CLKFBOUT_MULT  = 13,
   parameter int DIVCLK_DIVIDE  = 2,
   parameter int CLKOUT0_DIVIDE = 20,
   parameter int LOCK_CYCLES    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   sys_clk_ce_gen_if.master      bus
);

   localparam int N = CLKFBOUT_MULT;
   localparam int D = DIVCLK_DIVIDE * CLKOUT0_DIVIDE;

   // VCO window 800..1600 MHz from a 200 MHz reference reduces to 4*DIVCLK <= N <= 8*DIVCLK.
   localparam logic PARAM_ERR = (CLKFBOUT_MULT < 1) || (DIVCLK_DIVIDE < 1) ||
                                (CLKOUT0_DIVIDE < 1) || (LOCK_CYCLES < 1) ||
                                (2 * N > D) || (N < 4 * DIVCLK_DIVIDE) ||
                                (N > 8 * DIVCLK_DIVIDE);

   localparam int CE_W_RAW = $clog2(D + N);
   localparam int CE_W     = (CE_W_RAW < 1) ? 1 : CE_W_RAW;
   localparam int TG_W_RAW = $clog2(D + 2 * N);
   localparam int TG_W     = (TG_W_RAW < 1) ? 1 : TG_W_RAW;
   localparam int LK_W_RAW = $clog2(LOCK_CYCLES + 1);
   localparam int LK_W     = (LK_W_RAW < 1) ? 1 : LK_W_RAW;

   localparam logic [CE_W:0]   CE_INC    = (CE_W + 1)'(N);
   localparam logic [CE_W:0]   CE_MOD    = (CE_W + 1)'(D);
   localparam logic [TG_W:0]   TG_INC    = (TG_W + 1)'(2 * N);
   localparam logic [TG_W:0]   TG_MOD    = (TG_W + 1)'(D);
   localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [LK_W-1:0]   lock_cnt_r, lock_cnt_nxt_s;
   logic [CE_W-1:0]   acc_ce_r, acc_ce_nxt_s, ce_step_s;
   logic [TG_W-1:0]   acc_tg_r, acc_tg_nxt_s, tg_step_s;
   logic [CE_W:0]     ce_sum_s;
   logic [TG_W:0]     tg_sum_s;
   logic              ce_wrap_s, tg_wrap_s;
   logic              ce_out_r, ce_nxt_s;
   logic              clk_out_r, clk_nxt_s;
   logic              locked_r, locked_nxt_s;

   // One accumulator step for both the enable and toggle phases. Wrap is the carry out of modulo D.
   always_comb begin
      ce_sum_s  = {1'b0, acc_ce_r} + CE_INC;
      tg_sum_s  = {1'b0, acc_tg_r} + TG_INC;
      ce_wrap_s = (ce_sum_s >= CE_MOD);
      tg_wrap_s = (tg_sum_s >= TG_MOD);
      if (ce_wrap_s) begin
         ce_step_s = CE_W'(ce_sum_s - CE_MOD);
      end else begin
         ce_step_s = ce_sum_s[CE_W-1:0];
      end
      if (tg_wrap_s) begin
         tg_step_s = TG_W'(tg_sum_s - TG_MOD);
      end else begin
         tg_step_s = tg_sum_s[TG_W-1:0];
      end
   end

   // Next state and next outputs. The entry edge already performs the first step from a cleared phase.
   always_comb begin
      state_nxt_s    = state_r;
      lock_cnt_nxt_s = lock_cnt_r;
      acc_ce_nxt_s   = acc_ce_r;
      acc_tg_nxt_s   = acc_tg_r;
      ce_nxt_s       = 1'b0;
      clk_nxt_s      = clk_out_r;
      locked_nxt_s   = locked_r;
      if (bus.pwrdwn || PARAM_ERR) begin
         state_nxt_s    = ST_WAIT;
         lock_cnt_nxt_s = '0;
         acc_ce_nxt_s   = '0;
         acc_tg_nxt_s   = '0;
         clk_nxt_s      = 1'b0;
         locked_nxt_s   = 1'b0;
      end else begin
         case (state_r)
            ST_WAIT: begin
               locked_nxt_s = 1'b0;
               clk_nxt_s    = 1'b0;
               if (lock_cnt_r == LOCK_LAST) begin
                  state_nxt_s    = ST_RUN;
                  lock_cnt_nxt_s = '0;
                  locked_nxt_s   = 1'b1;
                  acc_ce_nxt_s   = ce_step_s;
                  acc_tg_nxt_s   = tg_step_s;
                  ce_nxt_s       = ce_wrap_s;
                  clk_nxt_s      = tg_wrap_s;
               end else begin
                  lock_cnt_nxt_s = lock_cnt_r + LK_W'(1);
               end
            end
            ST_RUN: begin
               locked_nxt_s = 1'b1;
               acc_ce_nxt_s = ce_step_s;
               acc_tg_nxt_s = tg_step_s;
               ce_nxt_s     = ce_wrap_s;
               clk_nxt_s    = clk_out_r ^ tg_wrap_s;
            end
            default: begin
               state_nxt_s    = ST_WAIT;
               lock_cnt_nxt_s = '0;
               acc_ce_nxt_s   = '0;
               acc_tg_nxt_s   = '0;
               clk_nxt_s      = 1'b0;
               locked_nxt_s   = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_WAIT;
         lock_cnt_r <= '0;
         acc_ce_r   <= '0;
         acc_tg_r   <= '0;
         ce_out_r   <= 1'b0;
         clk_out_r  <= 1'b0;
         locked_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         lock_cnt_r <= lock_cnt_nxt_s;
         acc_ce_r   <= acc_ce_nxt_s;
         acc_tg_r   <= acc_tg_nxt_s;
         ce_out_r   <= ce_nxt_s;
         clk_out_r  <= clk_nxt_s;
         locked_r   <= locked_nxt_s;
      end
   end

   assign bus.ce_out    = ce_out_r;
   assign bus.clk_out   = clk_out_r;
   assign bus.locked    = locked_r;
   assign bus.param_err = PARAM_ERR;

endmodule

// File: tb/tb_sys_clk_ce_gen.sv
// Bench for sys_clk_ce_gen. A rate model built on floor arithmetic is compared every cycle,
// and directed scenarios add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_sys_clk_ce_gen;
   localparam int N    = 13;
   localparam int D    = 40;
   localparam int LOCK = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   good   = 0;
   int   mt;
   int   e, tf, cnt_ce, cnt_tg, first_t, clk_at2;
   logic prev_clk;

   always #5 clk = ~clk;

   sys_clk_ce_gen_if bus_a ();
   sys_clk_ce_gen_if bus_b ();

   sys_clk_ce_gen #(.CLKFBOUT_MULT(13), .DIVCLK_DIVIDE(2), .CLKOUT0_DIVIDE(20), .LOCK_CYCLES(8))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   sys_clk_ce_gen #(.CLKFBOUT_MULT(30), .DIVCLK_DIVIDE(1), .CLKOUT0_DIVIDE(20), .LOCK_CYCLES(8))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // A strobe appears in cycle t when floor(t*N/D) steps up.
   function automatic int exp_ce(input int t);
      if (t < 1) return 0;
      return ((t * N) / D != ((t - 1) * N) / D) ? 1 : 0;
   endfunction

   // clk_out equals the parity of the number of half-periods elapsed.
   function automatic int exp_clk(input int t);
      if (t < 1) return 0;
      return ((2 * t * N) / D) % 2;
   endfunction

   // Model update on each edge, then a compare of both DUTs just after it.
   always @(posedge clk) begin
      if (rst || bus_a.pwrdwn) good = 0;
      else good = good + 1;
      #1;
      mt = good - LOCK + 1;
      chk("locked",    int'(bus_a.locked),    (good >= LOCK) ? 1 : 0);
      chk("ce_out",    int'(bus_a.ce_out),    exp_ce(mt));
      chk("clk_out",   int'(bus_a.clk_out),   exp_clk(mt));
      chk("param_err", int'(bus_a.param_err), 0);
      chk("bad_locked",  int'(bus_b.locked),  0);
      chk("bad_ce_out",  int'(bus_b.ce_out),  0);
      chk("bad_clk_out", int'(bus_b.clk_out), 0);
   end

   task automatic measure_lock(output int edges);
      edges = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus_a.locked === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic first_ce(output int t_first);
      t_first = 0;
      for (int t = 1; t <= 20; t++) begin
         if (bus_a.ce_out === 1'b1) begin
            t_first = t;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus_a.pwrdwn = 1'b0;
      bus_b.pwrdwn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_locked", int'(bus_a.locked), 0);
      rst = 1'b0;

      // Release, lock delay, then 400 free-running cycles
      measure_lock(e);
      chk("lock_delay_release", e, 8);
      cnt_ce = 0; cnt_tg = 0; first_t = 0; clk_at2 = 0; prev_clk = 1'b0;
      for (int t = 1; t <= 400; t++) begin
         if (bus_a.ce_out === 1'b1) begin
            cnt_ce++;
            if (first_t == 0) first_t = t;
         end
         if (bus_a.clk_out !== prev_clk) cnt_tg++;
         prev_clk = bus_a.clk_out;
         if (t == 2) clk_at2 = int'(bus_a.clk_out);
         @(posedge clk);
         #1;
      end
      chk("ce_count_400", cnt_ce, 130);
      chk("tg_count_400", cnt_tg, 260);
      chk("first_ce_t", first_t, 4);
      chk("clk_high_t2", clk_at2, 1);

      // One-cycle reset during RUN
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_locked", int'(bus_a.locked), 0);
      chk("rst_ce",     int'(bus_a.ce_out), 0);
      chk("rst_clk",    int'(bus_a.clk_out), 0);
      @(negedge clk);
      rst = 1'b0;
      measure_lock(e);
      chk("lock_delay_rst", e, 8);
      first_ce(tf);
      chk("first_ce_after_rst", tf, 4);

      // Three-cycle power-down during RUN
      repeat (7) @(negedge clk);
      bus_a.pwrdwn = 1'b1;
      @(posedge clk);
      #1;
      chk("pd_locked", int'(bus_a.locked), 0);
      chk("pd_clk",    int'(bus_a.clk_out), 0);
      repeat (3) @(negedge clk);
      bus_a.pwrdwn = 1'b0;
      measure_lock(e);
      chk("lock_delay_pd", e, 8);
      first_ce(tf);
      chk("first_ce_after_pd", tf, 4);

      // Power-down held while reset falls
      @(negedge clk);
      rst = 1'b1;
      bus_a.pwrdwn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("pd_hold_locked", int'(bus_a.locked), 0);
      bus_a.pwrdwn = 1'b0;
      measure_lock(e);
      chk("lock_delay_pd_hold", e, 8);
      repeat (20) @(negedge clk);

      chk("bad_param_err",  int'(bus_b.param_err), 1);
      chk("good_param_err", int'(bus_a.param_err), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
